neuron_scheduler: RTL and testbench

NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

---
 rtl/neuron_scheduler_pkg.sv | 28 ++
 rtl/neuron_scheduler_if.sv | 39 +++
 rtl/neuron_scheduler_loader.sv | 35 +++
 rtl/neuron_scheduler.sv | 116 +++++++++++
 tb/tb_neuron_scheduler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/neuron_scheduler_pkg.sv
// Shared encodings and sizing helpers for the time-multiplexed neuron scheduler.
package neuron_sched_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD_X = 2'b00,
    CMD_LOAD_W = 2'b01,
    CMD_STEP   = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_X,
    ST_LOAD_W,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic int bytes_per_vec(input int synapses);
    return synapses / 8;
  endfunction

  // Select/index width, kept at least one bit so a single-neuron build still elaborates.
  function automatic int sel_bits(input int neurons);
    return (neurons > 1) ? $clog2(neurons) : 1;
  endfunction

endpackage

// File: rtl/neuron_scheduler_if.sv
// Command, byte-stream and datapath signals of the neuron scheduler.
interface neuron_scheduler_if #(
  parameter int NEURONS       = 4,
  parameter int SYNAPSES      = 32,
  parameter int MEMBRANE_BITS = 7
);
  import neuron_sched_pkg::*;
  localparam int SELW = sel_bits(NEURONS);

  logic                     cmd_valid;
  logic [1:0]               cmd;
  logic [SELW-1:0]          cmd_sel;
  logic                     cmd_ready;
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic [SYNAPSES-1:0]      neu_inputs;
  logic [SYNAPSES-1:0]      neu_weights;
  logic [MEMBRANE_BITS-1:0] neu_last_membrane;
  logic [MEMBRANE_BITS-1:0] neu_new_membrane;
  logic                     neu_spike;
  logic                     neu_enable;
  logic                     busy;
  logic [NEURONS-1:0]       spike_vec;
  logic                     spike_valid;

  modport master (
    output cmd_valid, cmd, cmd_sel, in_valid, in_data, neu_new_membrane, neu_spike,
    input  cmd_ready, in_ready, neu_inputs, neu_weights, neu_last_membrane,
           neu_enable, busy, spike_vec, spike_valid
  );

  modport slave (
    input  cmd_valid, cmd, cmd_sel, in_valid, in_data, neu_new_membrane, neu_spike,
    output cmd_ready, in_ready, neu_inputs, neu_weights, neu_last_membrane,
           neu_enable, busy, spike_vec, spike_valid
  );

endinterface

// File: rtl/neuron_scheduler_loader.sv
// Byte counter and shift stage shared by input and weight loads; last_o flags the final byte.
module sched_byte_loader #(
  parameter int SYNAPSES = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                accept_i,
  input  logic [7:0]          data_i,
  input  logic [SYNAPSES-1:0] vec_i,
  output logic [SYNAPSES-1:0] vec_o,
  output logic                last_o
);
  import neuron_sched_pkg::*;

  localparam int BPV = bytes_per_vec(SYNAPSES);
  localparam int CW  = (BPV > 1) ? $clog2(BPV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BPV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = accept_i && (cnt_q == LAST_CNT);
  // Oldest byte falls off the top; the newest byte lands in bits 7:0.
  assign vec_o  = SYNAPSES'({vec_i, data_i});

  always_comb begin
    cnt_d = cnt_q;
    if (accept_i) cnt_d = last_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Shares one neuron datapath across NEURONS virtual neurons, one per RUN cycle.
// NEURON_SCHED_AUTO_STEP_EN: a completed input load starts a step without a command.
module neuron_scheduler #(
  parameter int NEURONS       = 4,
  parameter int SYNAPSES      = 32,
  parameter int MEMBRANE_BITS = 7
) (
  input  logic         clk,
  input  logic         reset,
  neuron_scheduler_if.slave bus
);
  import neuron_sched_pkg::*;

  localparam int SELW = sel_bits(NEURONS);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(NEURONS - 1);

  state_e                   state_q, state_d;
  logic [SELW-1:0]          sel_q, idx_q;
  logic [SYNAPSES-1:0]      x_q;
  logic [SYNAPSES-1:0]      w_q   [NEURONS];
  logic [MEMBRANE_BITS-1:0] mem_q [NEURONS];
  logic [NEURONS-1:0]       spk_q, spk_d, svec_q;
  logic                     loading, cmd_acc, byte_acc, ld_last, sel_ok, run_last;
  logic [SYNAPSES-1:0]      ld_cur, ld_vec;

  assign loading  = (state_q == ST_LOAD_X) || (state_q == ST_LOAD_W);
  assign cmd_acc  = bus.cmd_valid && (state_q == ST_IDLE);
  assign byte_acc = bus.in_valid && loading;
  assign sel_ok   = (int'(sel_q) < NEURONS);
  assign run_last = (idx_q == LAST_IDX);
  assign ld_cur   = (state_q == ST_LOAD_X) ? x_q : w_q[sel_q];

  sched_byte_loader #(.SYNAPSES(SYNAPSES)) u_loader (
    .clk      (clk),
    .reset    (reset),
    .accept_i (byte_acc),
    .data_i   (bus.in_data),
    .vec_i    (ld_cur),
    .vec_o    (ld_vec),
    .last_o   (ld_last)
  );

  assign bus.cmd_ready         = (state_q == ST_IDLE);
  assign bus.in_ready          = loading;
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.neu_enable        = (state_q == ST_RUN);
  assign bus.spike_valid       = (state_q == ST_DONE);
  assign bus.spike_vec         = svec_q;
  assign bus.neu_inputs        = x_q;
  assign bus.neu_weights       = (state_q == ST_RUN) ? w_q[idx_q]   : w_q[0];
  assign bus.neu_last_membrane = (state_q == ST_RUN) ? mem_q[idx_q] : mem_q[0];

  always_comb begin
    state_d = state_q;
    spk_d   = spk_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (cmd_e'(bus.cmd))
            CMD_LOAD_X: state_d = ST_LOAD_X;
            CMD_LOAD_W: state_d = ST_LOAD_W;
            CMD_STEP:   state_d = ST_RUN;
            default:    state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_X: begin
        if (ld_last) begin
`ifdef NEURON_SCHED_AUTO_STEP_EN
          state_d = ST_RUN;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_LOAD_W: if (ld_last) state_d = ST_IDLE;
      ST_RUN: begin
        spk_d[idx_q] = bus.neu_spike;
        if (run_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      spk_q   <= '0;
      svec_q  <= '0;
      for (int i = 0; i < NEURONS; i++) begin
        w_q[i]   <= '1;
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (cmd_acc && (bus.cmd == CMD_LOAD_W)) sel_q <= bus.cmd_sel;
      if (cmd_acc && (bus.cmd == CMD_CLEAR)) begin
        for (int i = 0; i < NEURONS; i++) mem_q[i] <= '0;
      end
      if (byte_acc && (state_q == ST_LOAD_X)) x_q <= ld_vec;
      // Out-of-range selects still drain their bytes but never touch a weight.
      if (byte_acc && (state_q == ST_LOAD_W) && sel_ok) w_q[sel_q] <= ld_vec;
      if (state_q == ST_RUN) begin
        mem_q[idx_q] <= bus.neu_new_membrane;
        spk_q        <= spk_d;
        idx_q        <= run_last ? '0 : idx_q + 1'b1;
        if (run_last) svec_q <= spk_d;
      end
    end
  end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed bench for neuron_scheduler with a per-cycle comparison against a transaction-level model.
module tb_neuron_scheduler;
  import neuron_sched_pkg::*;

  localparam int N = 4, S = 32, MB = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  neuron_scheduler_if #(.NEURONS(N), .SYNAPSES(S), .MEMBRANE_BITS(MB)) bus ();
  neuron_scheduler #(.NEURONS(N), .SYNAPSES(S), .MEMBRANE_BITS(MB)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  // 3-bit select variant: NEURONS=5 so cmd_sel can name neurons that do not exist.
  neuron_scheduler_if #(.NEURONS(5), .SYNAPSES(S), .MEMBRANE_BITS(MB)) bus5 ();
  neuron_scheduler #(.NEURONS(5), .SYNAPSES(S), .MEMBRANE_BITS(MB)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5.slave));

  // Datapath stub: new = last + 1, spike when new >= 3.
  assign bus.neu_new_membrane  = bus.neu_last_membrane + 7'd1;
  assign bus.neu_spike         = ($signed(bus.neu_new_membrane) >= 7'sd3);
  assign bus5.neu_new_membrane = bus5.neu_last_membrane + 7'd1;
  assign bus5.neu_spike        = ($signed(bus5.neu_new_membrane) >= 7'sd3);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: architectural contents plus what the outputs must show this cycle.
  logic [S-1:0]  m_x;
  logic [S-1:0]  m_w   [N];
  logic [MB-1:0] m_mem [N];
  logic [N-1:0]  m_svec, m_spk;
  logic e_busy, e_cr, e_ir, e_en, e_sv;
  int   e_k;
  logic chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmd_ready",   bus.cmd_ready,   e_cr);
      chk("in_ready",    bus.in_ready,    e_ir);
      chk("busy",        bus.busy,        e_busy);
      chk("neu_enable",  bus.neu_enable,  e_en);
      chk("spike_valid", bus.spike_valid, e_sv);
      chk("spike_vec",   bus.spike_vec,   m_svec);
      chk("neu_inputs",  bus.neu_inputs,  m_x);
      chk("neu_weights", bus.neu_weights, m_w[e_k]);
      chk("neu_last_membrane", bus.neu_last_membrane, m_mem[e_k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, cr, ir, en, sv, input int k);
    e_busy = b; e_cr = cr; e_ir = ir; e_en = en; e_sv = sv; e_k = k;
  endtask

  task automatic model_reset();
    m_x = '0; m_svec = '0; m_spk = '0;
    for (int i = 0; i < N; i++) begin
      m_w[i] = '1;
      m_mem[i] = '0;
    end
    set_exp(0, 1, 0, 0, 0, 0);
  endtask

  // Body of a step once the DUT is evaluating neuron 0; abort_at asserts reset in that cycle.
  task automatic run_body(input bit noise, input int abort_at);
    for (int k = 0; k < N; k++) begin
      set_exp(1, 0, 0, 1, 0, k);
      if (noise) begin
        bus.cmd_valid = 1'b1; bus.cmd = CMD_LOAD_X;
        bus.in_valid = 1'b1;  bus.in_data = 8'h5A;
      end
      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.in_valid = 1'b0;
        model_reset();
        return;
      end
      tick();
      m_mem[k] = m_mem[k] + 7'd1;
      m_spk[k] = ($signed(m_mem[k]) >= 3);
    end
    m_svec = m_spk;
    set_exp(1, 0, 0, 0, 1, 0);
    tick();
    bus.cmd_valid = 1'b0; bus.in_valid = 1'b0;
    set_exp(0, 1, 0, 0, 0, 0);
  endtask

  task automatic step(input bit noise, input int abort_at);
    bus.cmd_valid = 1'b1; bus.cmd = CMD_STEP;
    tick();
    bus.cmd_valid = 1'b0;
    run_body(noise, abort_at);
  endtask

  task automatic load(input bit is_w, input logic [1:0] sel, input logic [31:0] bytes, input bit gap);
    bus.cmd_valid = 1'b1; bus.cmd = is_w ? CMD_LOAD_W : CMD_LOAD_X; bus.cmd_sel = sel;
    tick();
    bus.cmd_valid = 1'b0;
    set_exp(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < S / 8; i++) begin
      if (gap && i == 1) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1; bus.in_data = bytes[31 - 8*i -: 8];
      tick();
      if (!is_w) m_x = {m_x[S-9:0], bytes[31 - 8*i -: 8]};
      else if (int'(sel) < N) m_w[sel] = {m_w[sel][S-9:0], bytes[31 - 8*i -: 8]};
    end
    bus.in_valid = 1'b0;
`ifdef NEURON_SCHED_AUTO_STEP_EN
    if (!is_w) run_body(0, -1);
    else set_exp(0, 1, 0, 0, 0, 0);
`else
    set_exp(0, 1, 0, 0, 0, 0);
`endif
  endtask

  task automatic clear_mem();
    bus.cmd_valid = 1'b1; bus.cmd = CMD_CLEAR;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
  endtask

  task automatic run5(input logic [2:0] sel, input int zero_idx);
    bus5.cmd_valid = 1'b1; bus5.cmd = CMD_LOAD_W; bus5.cmd_sel = sel;
    tick();
    bus5.cmd_valid = 1'b0;
    bus5.in_valid = 1'b1; bus5.in_data = 8'h00;
    repeat (S / 8) tick();
    bus5.in_valid = 1'b0;
    chk("sel5_idle_after_bytes", {bus5.in_ready, bus5.cmd_ready}, 2'b01);
    bus5.cmd_valid = 1'b1; bus5.cmd = CMD_STEP;
    tick();
    bus5.cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("sel5_enable", bus5.neu_enable, 1'b1);
      chk("sel5_weights", bus5.neu_weights, (k == zero_idx) ? 32'h0 : 32'hFFFF_FFFF);
      tick();
    end
    chk("sel5_spike_valid", bus5.spike_valid, 1'b1);
    tick();
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd = 2'b00; bus.cmd_sel = '0;
    bus.in_valid = 1'b0;  bus.in_data = 8'h00;
    bus5.cmd_valid = 1'b0; bus5.cmd = 2'b00; bus5.cmd_sel = '0;
    bus5.in_valid = 1'b0;  bus5.in_data = 8'h00;
    model_reset();
    reset = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    reset = 1'b0;

    chk("rst_weights_ones", bus.neu_weights, 32'hFFFF_FFFF);
    chk("rst_outputs", {bus.busy, bus.cmd_ready, bus.spike_valid, bus.spike_vec}, 7'b0100000);

    // Bytes offered while idle must be dropped.
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    tick(); tick();
    bus.in_valid = 1'b0;

    step(0, -1);
    step(1, -1);
    step(0, -1);
    chk("mem_after_3_steps", bus.neu_last_membrane, 7'd3);
    chk("svec_after_3_steps", bus.spike_vec, 4'b1111);

    clear_mem();
    chk("clear_mem", bus.neu_last_membrane, 7'd0);
    chk("clear_keeps_svec", bus.spike_vec, 4'b1111);

    load(0, 2'd0, 32'hAABB_CCDD, 1);
    chk("inputs_loaded", bus.neu_inputs, 32'hAABB_CCDD);
    chk("in_ready_after_4", bus.in_ready, 1'b0);

    load(1, 2'd2, 32'h0000_0000, 0);
    step(0, -1);
    chk("svec_low_membranes", bus.spike_vec, 4'b0000);

    load(1, 2'd1, 32'h1234_5678, 0);
    step(0, 2);
    chk("abort_svec", bus.spike_vec, 4'b0000);
    chk("abort_mem", bus.neu_last_membrane, 7'd0);
    chk("abort_idle", {bus.busy, bus.cmd_ready}, 2'b01);
    step(0, -1);

    run5(3'd5, -1);
    run5(3'd4, 4);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
